// File: rtl/logic_arb_pkg.sv
// Shared encodings for the two-requester logic-unit arbiter.
// The grant counters are only built when LOGIC_ARB_STATS_EN is defined.
package logic_arb_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: a counter at CNT_MAX stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] n;
        if (v == CNT_MAX) begin
            n = v;
        end else begin
            n = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

endpackage

// File: rtl/logic_unit_32bit.sv
// Bitwise AND/OR/XOR/NOR unit built from per-bit gate primitives.
// Purely combinational; the result is selected per bit by the op code.
module logic_unit_32bit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_nor;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            and u_and (w_and[gi], a[gi], b[gi]);
            or  u_or  (w_or[gi],  a[gi], b[gi]);
            xor u_xor (w_xor[gi], a[gi], b[gi]);
            nor u_nor (w_nor[gi], a[gi], b[gi]);
            assign result[gi] = (op == OP_AND) ? w_and[gi] :
                                (op == OP_OR)  ? w_or[gi]  :
                                (op == OP_XOR) ? w_xor[gi] : w_nor[gi];
        end
    endgenerate

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter feeding a shared logic unit into a one-entry output buffer.
// Optional per-requester grant counters are enabled by LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    buf_state_e       r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_result;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_lu_result;

    // Grant selection: operands never influence ready, and reset forces both low.
    always_comb begin
        w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (rst_n && w_can_accept) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else if (req0_valid) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_a        = w_gnt1 ? req1_a  : req0_a;
    assign w_b        = w_gnt1 ? req1_b  : req0_b;
    assign w_op       = w_gnt1 ? req1_op : req0_op;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;

    logic_unit_32bit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .a      (w_a),
        .b      (w_b),
        .op     (w_op),
        .result (w_lu_result)
    );

    // Output buffer FSM, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_result     <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end else begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end else if (rsp_ready) begin
                        r_state <= ST_EMPTY;
                    end else begin
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
            if (w_accept) begin
                r_id         <= w_gnt1;
                r_result     <= w_lu_result;
                r_last_grant <= w_gnt1;
            end else begin
                r_id         <= r_id;
                r_result     <= r_result;
                r_last_grant <= r_last_grant;
            end
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Saturating counts of accepted transfers per requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= {CNT_W{1'b0}};
            r_cnt1 <= {CNT_W{1'b0}};
        end else begin
            if (w_gnt0) begin
                r_cnt0 <= sat_inc(r_cnt0);
            end else begin
                r_cnt0 <= r_cnt0;
            end
            if (w_gnt1) begin
                r_cnt1 <= sat_inc(r_cnt1);
            end else begin
                r_cnt1 <= r_cnt1;
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed scoreboard bench for logic_unit_arbiter (default build, or with LOGIC_ARB_STATS_EN).
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    int          m_cnt0, m_cnt1;
`endif

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    logic        m_full;
    logic        m_last;
    logic [32:0] sb[$];

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshakes/response at negedge against the model, then advance.
    task automatic step();
        logic        can, e0, e1, nxt_full;
        logic [32:0] front;
        @(negedge clk);
        can = !m_full || rsp_ready;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst_n && can) begin
            if (req0_valid && req1_valid) begin
                e0 = m_last;
                e1 = ~m_last;
            end else if (req0_valid) begin
                e0 = 1'b1;
            end else if (req1_valid) begin
                e1 = 1'b1;
            end
        end
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
        if (m_full && sb.size() > 0) begin
            front = sb[0];
            chk("rsp_id", {63'd0, rsp_id}, {63'd0, front[32]});
            chk("rsp_result", {32'd0, rsp_result}, {32'd0, front[31:0]});
            if (rsp_ready) void'(sb.pop_front());
        end
        if (e0) sb.push_back({1'b0, model_op(req0_op, req0_a, req0_b)});
        if (e1) sb.push_back({1'b1, model_op(req1_op, req1_a, req1_b)});
        if (e0 || e1) m_last = e1;
        nxt_full = e0 || e1 || (m_full && !rsp_ready);
        @(posedge clk);
        if (!rst_n) begin
            m_full = 1'b0;
            m_last = 1'b1;
            sb.delete();
`ifdef LOGIC_ARB_STATS_EN
            m_cnt0 = 0;
            m_cnt1 = 0;
`endif
        end else begin
            m_full = nxt_full;
`ifdef LOGIC_ARB_STATS_EN
            if (e0 && m_cnt0 < 65535) m_cnt0++;
            if (e1 && m_cnt1 < 65535) m_cnt1++;
`endif
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00;   req1_op = 2'b00;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b0;
        m_full = 1'b0;
        m_last = 1'b1;
`ifdef LOGIC_ARB_STATS_EN
        m_cnt0 = 0;
        m_cnt1 = 0;
`endif
        step();
        step();
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single request on requester 0
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
        step();
        chk("and_valid", {63'd0, rsp_valid}, 64'd1);
        chk("and_id", {63'd0, rsp_id}, 64'd0);
        chk("and_result", {32'd0, rsp_result}, {32'd0, 32'hF000F000});
        req0_valid = 1'b0;
        step();

        // Op coverage on requester 1
        req1_a = 32'hAAAAAAAA; req1_b = 32'h0000FFFF; req1_valid = 1'b1;
        req1_op = 2'b01; step();
        chk("or_result", {32'd0, rsp_result}, {32'd0, 32'hAAAAFFFF});
        chk("or_id", {63'd0, rsp_id}, 64'd1);
        req1_op = 2'b10; step();
        chk("xor_result", {32'd0, rsp_result}, {32'd0, 32'hAAAA5555});
        req1_op = 2'b11; step();
        chk("nor_result", {32'd0, rsp_result}, {32'd0, 32'h55550000});
        req1_valid = 1'b0;
        step();
        step();

        // Contention: alternating grants, one result per cycle
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b10; req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F;
        req1_op = 2'b11; req1_a = 32'h00FF00FF; req1_b = 32'h11111111;
        for (int i = 0; i < 8; i++) begin
            req0_a = req0_a + 32'd3;
            req1_b = req1_b ^ 32'h80000001;
            step();
            chk("stream_valid", {63'd0, rsp_valid}, 64'd1);
        end

        // Backpressure while FULL, then same-cycle refill
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req0_a = req0_a + 32'd1;
            step();
        end
        rsp_ready = 1'b1;
        step();
        step();

        // Valid dropped before grant loses nothing
        rsp_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        step();
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        step();
        step();

        // Reset while FULL, then contention goes to requester 0
        rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
        step();
        step();
        req0_valid = 1'b0; req1_valid = 1'b1;
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        chk("pre_reset_full", {63'd0, rsp_valid}, 64'd1);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        chk("post_reset_valid", {63'd0, rsp_valid}, 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("post_reset_grant_id", {63'd0, rsp_id}, 64'd0);
        step();
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();

`ifdef LOGIC_ARB_STATS_EN
        chk("cnt1_before", {48'd0, grant_cnt1}, m_cnt1);
        req0_valid = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        req0_valid = 1'b0;
        step();
        chk("grant_cnt0_sat", {48'd0, grant_cnt0}, 64'hFFFF);
        chk("grant_cnt1_held", {48'd0, grant_cnt1}, m_cnt1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
